// File: rtl/fast_mult_seq.sv
// fast_mult_seq: sequential WIDTH x WIDTH multiplier. It walks every CHUNK-bit
// digit pair through one shared CHUNK x CHUNK product ROM and sums the results.
// Ports:
//   clk, reset (async, active-low)
//   io_in_valid/io_in_ready, io_lhs, io_rhs, io_signed : operand side
//   io_out_valid/io_out_ready, io_out                  : product side
module fast_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [WIDTH-1:0]   io_lhs,
  input  logic [WIDTH-1:0]   io_rhs,
  input  logic               io_signed,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [2*WIDTH-1:0] io_out
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int RW = 2 * CHUNK;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [PW-1:0]   out_q, out_d;

  logic [CHUNK-1:0] a_dig;
  logic [CHUNK-1:0] b_dig;
  logic [RW-1:0]    rom_q;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_nx;

  // Product ROM, entry {a,b} = a*b with a in the upper digit.
  function automatic logic [RW-1:0] rom(
    input logic [RW-1:0] idx
  );
    return RW'(idx[RW-1:CHUNK]) * RW'(idx[CHUNK-1:0]);
  endfunction

  // |x| in WIDTH bits; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  always_comb begin
    a_dig  = CHUNK'(a_q >> (CHUNK * int'(i_q)));
    b_dig  = CHUNK'(b_q >> (CHUNK * int'(j_q)));
    rom_q  = rom({a_dig, b_dig});
    pp     = PW'(rom_q) << (CHUNK * (int'(i_q) + int'(j_q)));
    acc_nx = acc_q + pp;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          a_d     = io_signed ? mag(io_lhs) : io_lhs;
          b_d     = io_signed ? mag(io_rhs) : io_rhs;
          neg_d   = io_signed &
                    (io_lhs[WIDTH-1] ^ io_rhs[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_nx;
        if (j_q == IW'(N - 1)) begin
          j_d = '0;
          if (i_q == IW'(N - 1)) begin
            i_d     = '0;
            out_d   = neg_q ? PW'(-acc_nx) : acc_nx;
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      out_q   <= out_d;
    end
  end

  assign io_in_ready  = (state_q == IDLE);
  assign io_out_valid = (state_q == DONE);
  assign io_out       = out_q;

endmodule

// File: tb/tb_fast_mult_seq.sv
// tb_fast_mult_seq: directed bench for fast_mult_seq.
// Covers reset, signed/unsigned, back-pressure, reset abort, random, sweep.
module tb_fast_mult_seq;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_lhs;
  logic [7:0]  io_rhs;
  logic        io_signed;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out;

  logic        v4, v12, v2;
  logic        ir4, ir12, ir2;
  logic        ov4, ov12, ov2;
  logic [7:0]  o4;
  logic [23:0] o12;
  logic [15:0] o2;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int prev_acc = -1;

  always #5 clk = clk_en ? ~clk : 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  fast_mult_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_lhs(io_lhs), .io_rhs(io_rhs), .io_signed(io_signed),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out(io_out)
  );

  fast_mult_seq #(.WIDTH(4), .CHUNK(4)) d4 (
    .clk(clk), .reset(reset),
    .io_in_valid(v4), .io_in_ready(ir4),
    .io_lhs(4'hF), .io_rhs(4'hF), .io_signed(1'b0),
    .io_out_valid(ov4), .io_out_ready(1'b1),
    .io_out(o4)
  );

  fast_mult_seq #(.WIDTH(12), .CHUNK(4)) d12 (
    .clk(clk), .reset(reset),
    .io_in_valid(v12), .io_in_ready(ir12),
    .io_lhs(12'hFFF), .io_rhs(12'hFFF), .io_signed(1'b0),
    .io_out_valid(ov12), .io_out_ready(1'b1),
    .io_out(o12)
  );

  fast_mult_seq #(.WIDTH(8), .CHUNK(2)) d2 (
    .clk(clk), .reset(reset),
    .io_in_valid(v2), .io_in_ready(ir2),
    .io_lhs(8'hAB), .io_rhs(8'hCD), .io_signed(1'b0),
    .io_out_valid(ov2), .io_out_ready(1'b1),
    .io_out(o2)
  );

  task automatic chk(
    input logic [63:0] obs,
    input logic [63:0] exp,
    input string tag
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(
    input logic [7:0]  l,
    input logic [7:0]  r,
    input logic        s,
    input logic [15:0] e,
    input bit          rnd,
    input string       tag
  );
    int n;
    int lat;
    int t;
    io_lhs = l;
    io_rhs = r;
    io_signed = s;
    io_in_valid = 1'b1;
    n = 0;
    while (!io_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(64'(io_in_ready), 64'd1, {tag, "_inrdy"});
    @(posedge clk); #1;
    t = cyc;
    io_in_valid = 1'b0;
    io_lhs = ~l;
    io_rhs = ~r;
    if (prev_acc >= 0)
      chk(64'(t - prev_acc >= 6), 64'd1, {tag, "_space"});
    prev_acc = t;
    chk(64'(io_in_ready), 64'd0, {tag, "_busy"});
    lat = 0;
    while (!io_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk(64'(lat), 64'd4, {tag, "_lat"});
    chk(64'(io_out), 64'(e), {tag, "_out"});
    n = 0;
    do begin
      io_out_ready = rnd ? 1'($urandom) : 1'b1;
      @(posedge clk); #1; n++;
      if (!io_out_ready) begin
        chk(64'(io_out), 64'(e), {tag, "_hold"});
        chk(64'(io_in_ready), 64'd0, {tag, "_holdrdy"});
      end
    end while (!io_out_ready && n < 50);
    io_out_ready = 1'b0;
    chk(64'(io_out_valid), 64'd0, {tag, "_vdrop"});
    chk(64'(io_in_ready), 64'd1, {tag, "_idle"});
  endtask

  task automatic sw(
    input int          sel,
    input logic [63:0] e,
    input int          el,
    input string       tag
  );
    int lat;
    logic ov;
    logic ir;
    logic [63:0] o;
    ir = (sel == 0) ? ir4 : (sel == 1) ? ir12 : ir2;
    chk(64'(ir), 64'd1, {tag, "_inrdy"});
    v4 = (sel == 0);
    v12 = (sel == 1);
    v2 = (sel == 2);
    @(posedge clk); #1;
    v4 = 1'b0; v12 = 1'b0; v2 = 1'b0;
    lat = 0;
    ov = 1'b0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1; lat++;
      ov = (sel == 0) ? ov4 : (sel == 1) ? ov12 : ov2;
    end
    o = (sel == 0) ? 64'(o4) : (sel == 1) ? 64'(o12) : 64'(o2);
    chk(64'(lat), 64'(el), {tag, "_lat"});
    chk(o, e, {tag, "_out"});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] e;
    logic signed [15:0] sp;

    reset = 1'b0;
    io_in_valid = 1'b0;
    io_lhs = '0;
    io_rhs = '0;
    io_signed = 1'b0;
    io_out_ready = 1'b0;
    v4 = 1'b0; v12 = 1'b0; v2 = 1'b0;
    #1;
    chk(64'(io_out), 64'd0, "rst_out");
    chk(64'(io_out_valid), 64'd0, "rst_valid");
    chk(64'(io_in_ready), 64'd1, "rst_ready");
    #21 reset = 1'b1;
    @(posedge clk); #1;

    run(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, "u_ff_ff");
    run(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, "s_fd_05");
    run(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, "s_80_80");
    run(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0, "s_80_7f");
    run(8'h00, 8'h80, 1'b1, 16'h0000, 1'b0, "s_00_80");
    run(8'h80, 8'h80, 1'b0, 16'h4000, 1'b0, "u_80_80");
    run(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0, "u_fd_05");

    io_lhs = 8'h0C; io_rhs = 8'h0B; io_signed = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clk); #1;
    io_in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk(64'(io_out_valid), 64'd1, "bp_valid");
    for (int c = 0; c < 10; c++) begin
      io_in_valid = 1'b1;
      io_lhs = 8'h55; io_rhs = 8'h66;
      @(posedge clk); #1;
      chk(64'(io_out), 64'h84, "bp_out");
      chk(64'(io_out_valid), 64'd1, "bp_hold");
      chk(64'(io_in_ready), 64'd0, "bp_rdy");
    end
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clk); #1;
    io_out_ready = 1'b0;
    chk(64'(io_out_valid), 64'd0, "bp_drop");
    chk(64'(io_in_ready), 64'd1, "bp_idle");
    prev_acc = -1;
    run(8'h07, 8'h09, 1'b0, 16'h003F, 1'b0, "bp_next");

    io_lhs = 8'h21; io_rhs = 8'h43; io_signed = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clk); #1;
    io_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    clk_en = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    chk(64'(io_out), 64'd0, "abort_out");
    chk(64'(io_out_valid), 64'd0, "abort_valid");
    chk(64'(io_in_ready), 64'd1, "abort_ready");
    #3 reset = 1'b1;
    #3 clk_en = 1'b1;
    @(posedge clk); #1;
    run(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, "post_rst");

    for (int k = 0; k < 100; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      if (s) begin
        sp = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        e = sp;
      end else begin
        e = {8'h00, a} * {8'h00, b};
      end
      run(a, b, s, e, 1'b1, "rnd");
    end

    sw(0, 64'hE1, 1, "w4");
    sw(1, 64'hFFE001, 9, "w12");
    sw(2, 64'h88EF, 16, "c2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
